// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response handshake and data-memory bus of the load/store unit
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic        mem_read_ctrl;
    logic        mem_write_ctrl;
    logic [14:0] mem_address;
    logic [1:0]  addr_allign;
    logic        B;
    logic        H;
    logic [31:0] mem_data_write;
    logic [31:0] mem_data_read;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_data_read,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
               mem_read_ctrl, mem_write_ctrl, mem_address, addr_allign, B, H, mem_data_write
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_data_read,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
               mem_read_ctrl, mem_write_ctrl, mem_address, addr_allign, B, H, mem_data_write
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller with legality checks and load extension
module lsu_ctrl (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        uns_q;
    logic        bad_f3;
    logic        bad_range;
    logic        bad_align;
    logic [1:0]  cause;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] ext;

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;

    // classify the incoming request: funct3 beats range beats alignment
    always_comb begin
        bad_f3    = bus.req_we ? (bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11))
                               : ((bus.req_funct3 == 3'b011) | (bus.req_funct3[2:1] == 2'b11));
        bad_range = |bus.req_addr[31:17];
        bad_align = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                    ((bus.req_funct3[1:0] == 2'b10) & (|bus.req_addr[1:0]));
        cause     = bad_f3 ? 2'b11 : bad_range ? 2'b10 : bad_align ? 2'b01 : 2'b00;
    end

    // pick the addressed lane out of the memory word and extend it
    always_comb begin
        shifted = bus.mem_data_read >> {bus.addr_allign, 3'b000};
        half    = bus.addr_allign[1] ? bus.mem_data_read[31:16] : bus.mem_data_read[15:0];
        ext     = bus.H ? {{16{~uns_q & half[15]}}, half}
                : bus.B ? {{24{~uns_q & shifted[7]}}, shifted[7:0]}
                : bus.mem_data_read;
    end

    // request capture, one-cycle memory access, response hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            uns_q              <= 1'b0;
            bus.resp_rdata     <= '0;
            bus.resp_err       <= 1'b0;
            bus.resp_cause     <= 2'b00;
            bus.mem_read_ctrl  <= 1'b0;
            bus.mem_write_ctrl <= 1'b0;
            bus.mem_address    <= '0;
            bus.addr_allign    <= 2'b00;
            bus.B              <= 1'b0;
            bus.H              <= 1'b0;
            bus.mem_data_write <= '0;
        end else begin
            bus.mem_read_ctrl  <= 1'b0;
            bus.mem_write_ctrl <= 1'b0;
            if (state == IDLE) begin
                if (bus.req_valid) begin
                    uns_q              <= bus.req_funct3[2];
                    bus.mem_address    <= bus.req_addr[16:2];
                    bus.addr_allign    <= bus.req_addr[1:0];
                    bus.B              <= bus.req_funct3[1:0] == 2'b00;
                    bus.H              <= bus.req_funct3[1:0] == 2'b01;
                    bus.mem_data_write <= bus.req_wdata;
                    bus.resp_rdata     <= '0;
                    bus.resp_err       <= cause != 2'b00;
                    bus.resp_cause     <= cause;
                    bus.mem_read_ctrl  <= (cause == 2'b00) & ~bus.req_we;
                    bus.mem_write_ctrl <= (cause == 2'b00) & bus.req_we;
                    state              <= (cause == 2'b00) ? ACCESS : RESP;
                end
            end else if (state == ACCESS) begin
                if (bus.mem_read_ctrl) bus.resp_rdata <= ext;
                state <= RESP;
            end else if (state == RESP) begin
                if (bus.resp_ready) state <= IDLE;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized load/store traffic against a byte-level memory model
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   both_cnt = 0;
    logic [31:0] mem [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic [14:0] acc_addr;
    logic [1:0]  acc_allign;
    logic [1:0]  acc_bh;
    logic [31:0] last_rdata;

    lsu_ctrl_if bus ();
    lsu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // data memory: samples the bus on the falling edge and steers store lanes itself
    always @(negedge clk) begin
        if (bus.mem_read_ctrl && bus.mem_write_ctrl) both_cnt++;
        if (bus.mem_read_ctrl || bus.mem_write_ctrl) begin
            acc_addr   = bus.mem_address;
            acc_allign = bus.addr_allign;
            acc_bh     = {bus.B, bus.H};
        end
        if (bus.mem_read_ctrl) begin
            rd_cnt++;
            bus.mem_data_read = mem[bus.mem_address];
        end
        if (bus.mem_write_ctrl) begin
            wr_cnt++;
            if (bus.B)      mem[bus.mem_address][8*bus.addr_allign +: 8] = bus.mem_data_write[7:0];
            else if (bus.H) mem[bus.mem_address][16*bus.addr_allign[1] +: 16] = bus.mem_data_write[15:0];
            else            mem[bus.mem_address] = bus.mem_data_write;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        int sz, c, idx, off, rd0, wr0;
        bit legal;
        logic [31:0] exp, w, m;
        sz    = 1 << f3[1:0];
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        c     = !legal ? 3 : (addr >= 32'h0002_0000) ? 2 : (addr % sz != 0) ? 1 : 0;
        idx   = int'(addr[16:2]);
        off   = int'(addr % 4);
        exp   = '0;
        if (c == 0 && !we) begin
            w   = ref_mem[idx] >> (8 * off);
            m   = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
            exp = w & m;
            if (!f3[2] && sz < 4 && exp[8*sz-1]) exp = exp | ~m;
        end
        if (c == 0 && we)
            for (int i = 0; i < sz; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        check("req_ready_idle", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (c == 0) begin
            check("rd_en", bus.mem_read_ctrl, !we);
            check("wr_en", bus.mem_write_ctrl, we);
            check("mem_address", bus.mem_address, idx);
            check("addr_allign", bus.addr_allign, off);
            check("b_h", {bus.B, bus.H}, {sz == 1, sz == 2});
            check("mem_data_write", bus.mem_data_write, wd);
            check("resp_early", bus.resp_valid, 0);
            @(posedge clk);
            #1;
            check("acc_addr_negedge", acc_addr, idx);
            check("acc_allign_negedge", acc_allign, off);
            check("acc_bh_negedge", acc_bh, {sz == 1, sz == 2});
        end
        check("resp_valid", bus.resp_valid, 1);
        check("req_ready_busy", bus.req_ready, 0);
        check("resp_rdata", bus.resp_rdata, exp);
        check("resp_err", bus.resp_err, c != 0);
        check("resp_cause", bus.resp_cause, c);
        check("rd_pulses", rd_cnt - rd0, (c == 0 && !we) ? 1 : 0);
        check("wr_pulses", wr_cnt - wr0, (c == 0 && we) ? 1 : 0);
        last_rdata = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'($urandom);
            bus.req_funct3 = 3'd2;
            bus.req_addr   = 32'h0000_0020;
            bus.req_wdata  = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid", bus.resp_valid, 1);
            check("hold_rdata", bus.resp_rdata, exp);
            check("hold_cause", bus.resp_cause, c);
            check("hold_ready", bus.req_ready, 0);
            check("hold_en", {bus.mem_read_ctrl, bus.mem_write_ctrl}, 0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", bus.resp_valid, 0);
        check("release_ready", bus.req_ready, 1);
        check("release_en", {bus.mem_read_ctrl, bus.mem_write_ctrl}, 0);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_funct3    = 3'd0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.resp_ready    = 1'b0;
        bus.mem_data_read = '0;
        #2;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", {bus.resp_err, bus.resp_cause}, 0);
        check("rst_mem_en", {bus.mem_read_ctrl, bus.mem_write_ctrl}, 0);
        check("rst_mem_bus", {bus.mem_address, bus.addr_allign, bus.B, bus.H}, 0);
        check("rst_mem_data", bus.mem_data_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        check("sw_mem_word", mem[4], 32'hDEAD_BEEF);
        do_req(1'b1, 3'd2, 32'h0000_0010, 32'h80FF_7F01, 0);
        do_req(1'b0, 3'd0, 32'h0000_0012, 32'h0, 0);
        check("lb_0x12", last_rdata, 32'hFFFF_FFFF);
        do_req(1'b0, 3'd4, 32'h0000_0013, 32'h0, 0);
        check("lbu_0x13", last_rdata, 32'h0000_0080);
        do_req(1'b0, 3'd1, 32'h0000_0012, 32'h0, 0);
        check("lh_0x12", last_rdata, 32'hFFFF_80FF);
        do_req(1'b0, 3'd5, 32'h0000_0010, 32'h0, 0);
        check("lhu_0x10", last_rdata, 32'h0000_7F01);
        do_req(1'b0, 3'd2, 32'h0000_0006, 32'h0, 0);
        do_req(1'b0, 3'd1, 32'h0002_0000, 32'h0, 0);
        do_req(1'b0, 3'd3, 32'h0000_0000, 32'h0, 0);
        do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 3);
        check("lw_hold", last_rdata, 32'h80FF_7F01);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h0000_0010;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("abort_rd_en_high", bus.mem_read_ctrl, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_en_async", bus.mem_read_ctrl, 0);
        check("abort_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_after_valid", bus.resp_valid, 0);
        check("abort_after_ready", bus.req_ready, 1);

        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(17, 31));
            do_req(1'($urandom), f3, a, $urandom, $urandom_range(0, 3));
        end
        check("never_both_enables", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
